// File: rtl/adc_avg_sequencer.sv
// Drives the serial ADC reader through 2^avg_log2 toggle-handshake conversions and publishes
// the per-channel mean. Define ADC_TIMEOUT_EN to add a per-conversion watchdog.
module adc_avg_sequencer #(
    parameter int unsigned NCH         = 8,
    parameter int unsigned DW          = 16,
    parameter int unsigned MAX_LOG2    = 7,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        avg_log2,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              adc_start,
    input  logic              adc_finish,
    input  logic [NCH*DW-1:0] adc_data,
    output logic [NCH*DW-1:0] avg_out
);

    localparam int unsigned AW = DW + MAX_LOG2;
    localparam int unsigned CW = MAX_LOG2 + 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StAccum, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        log2_q, log2_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q [NCH];
    logic [AW-1:0]     acc_d [NCH];
    logic [AW-1:0]     sum   [NCH];
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic [NCH*DW-1:0] avg_q, avg_d;
    logic [2:0]        log2_clamped;
    logic [CW-1:0]     n_target;
    logic              last_sample;
    logic              wd_expired;

    assign log2_clamped = (avg_log2 >= 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : avg_log2;
    assign n_target     = CW'(1) << log2_q;
    assign last_sample  = (cnt_q + CW'(1)) == n_target;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum[i] = acc_q[i] + AW'(adc_data[i*DW +: DW]);
        end
    end

`ifdef ADC_TIMEOUT_EN
    localparam int unsigned WDW = 13;

    logic [WDW-1:0] wd_q, wd_d;

    // Only WAIT advances the watchdog, so every entry into WAIT starts from zero.
    always_comb begin
        wd_d = '0;
        if (state_q == StWait) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign wd_expired = (wd_q == WDW'(TIMEOUT_CYC - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        log2_d  = log2_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        err_d   = err_q;
        avg_d   = avg_q;
        for (int i = 0; i < NCH; i++) begin
            acc_d[i] = acc_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    log2_d = log2_clamped;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    for (int i = 0; i < NCH; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                start_d = ~start_q;
                state_d = StWait;
            end
            StWait: begin
                if (adc_finish == start_q) begin
                    state_d = StAccum;
                end else if (wd_expired) begin
                    // Matching start to finish parks the reader; avg_out keeps its old value.
                    start_d = adc_finish;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StAccum: begin
                cnt_d = cnt_q + CW'(1);
                for (int i = 0; i < NCH; i++) begin
                    acc_d[i] = sum[i];
                end
                if (last_sample) begin
                    // Publish from the final sum so avg_out is valid while done is high.
                    for (int i = 0; i < NCH; i++) begin
                        avg_d[i*DW +: DW] = DW'(sum[i] >> log2_q);
                    end
                    state_d = StDone;
                end else begin
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            log2_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            avg_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            log2_q  <= log2_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            err_q   <= err_d;
            avg_q   <= avg_d;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign adc_start = start_q;
    assign avg_out   = avg_q;

endmodule
